// File: rtl/coin_feeder.sv
// Coin feeder: buys order_cnt drinks from a vending machine, one coin per cycle,
// choosing a coin plan per drink from the wallet captured at start.
module coin_feeder #(
  parameter int SELL_TIMEOUT = 4,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       order_cnt,
  input  logic [CNT_W-1:0] n_half,
  input  logic [CNT_W-1:0] n_one,
  input  logic             abort,
  input  logic             sell,
  input  logic [1:0]       change,
  output logic [1:0]       coin,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       drinks_got,
  output logic [CNT_W-1:0] half_left,
  output logic [CNT_W-1:0] one_left
);

  localparam int TMR_W = (SELL_TIMEOUT < 2) ? 1 : $clog2(SELL_TIMEOUT);

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_HALF = 2'b01;
  localparam logic [1:0] COIN_ONE  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    PLAN,
    INSERT,
    GAP,
    WAIT_SELL,
    FINISH
  } state_t;

  typedef enum logic [1:0] {
    PLAN_MIX,
    PLAN_ONES,
    PLAN_HALVES
  } plan_t;

  state_t           state_q, state_d;
  plan_t            plan_q, plan_d;
  logic [1:0]       idx_q, idx_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [3:0]       order_q, order_d;
  logic [3:0]       drinks_got_q, drinks_got_d;
  logic [CNT_W-1:0] half_left_q, half_left_d;
  logic [CNT_W-1:0] one_left_q, one_left_d;
  logic [1:0]       coin_q, coin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             fail;

  function automatic logic [1:0] plan_coin(plan_t p, logic [1:0] i);
    case (p)
      PLAN_MIX:  return (i == 2'd0) ? COIN_ONE : COIN_HALF;
      PLAN_ONES: return COIN_ONE;
      default:   return COIN_HALF;
    endcase
  endfunction

  function automatic logic plan_last(plan_t p, logic [1:0] i);
    return (p == PLAN_HALVES) ? (i == 2'd2) : (i == 2'd1);
  endfunction

  always_comb begin
    state_d      = state_q;
    plan_d       = plan_q;
    idx_d        = idx_q;
    tmr_d        = tmr_q;
    order_d      = order_q;
    drinks_got_d = drinks_got_q;
    half_left_d  = half_left_q;
    one_left_d   = one_left_q;
    coin_d       = COIN_NONE;
    done_d       = 1'b0;
    err_d        = 1'b0;
    fail         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          order_d      = order_cnt;
          half_left_d  = n_half;
          one_left_d   = n_one;
          drinks_got_d = 4'd0;
          state_d      = PLAN;
        end
      end
      PLAN: begin
        idx_d = 2'd0;
        if (sell) begin
          fail = 1'b1;
        end else if (abort || (drinks_got_q == order_q)) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else if ((one_left_q != '0) && (half_left_q != '0)) begin
          plan_d  = PLAN_MIX;
          state_d = INSERT;
        end else if (one_left_q >= CNT_W'(2)) begin
          plan_d  = PLAN_ONES;
          state_d = INSERT;
        end else if (half_left_q >= CNT_W'(3)) begin
          plan_d  = PLAN_HALVES;
          state_d = INSERT;
        end else begin
          fail = 1'b1;
        end
      end
      INSERT: begin
        if (sell) begin
          fail = 1'b1;
        end else if (plan_last(plan_q, idx_q)) begin
          state_d = WAIT_SELL;
          tmr_d   = '0;
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (sell) begin
          fail = 1'b1;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = INSERT;
        end
      end
      WAIT_SELL: begin
        if (sell) begin
          drinks_got_d = drinks_got_q + 4'd1;
          if ((change == COIN_HALF) && (half_left_q != '1)) begin
            half_left_d = half_left_q + CNT_W'(1);
          end
          state_d = PLAN;
        end else if (tmr_q == TMR_W'(SELL_TIMEOUT - 1)) begin
          fail = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fail) begin
      state_d = FINISH;
      err_d   = 1'b1;
    end

    // The coin and its wallet decrement appear in the same cycle the FSM sits in INSERT.
    if (state_d == INSERT) begin
      coin_d = plan_coin(plan_d, idx_d);
      if (coin_d == COIN_HALF) begin
        half_left_d = half_left_q - CNT_W'(1);
      end else begin
        one_left_d = one_left_q - CNT_W'(1);
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      plan_q       <= PLAN_MIX;
      idx_q        <= 2'd0;
      tmr_q        <= '0;
      order_q      <= 4'd0;
      drinks_got_q <= 4'd0;
      half_left_q  <= '0;
      one_left_q   <= '0;
      coin_q       <= COIN_NONE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      plan_q       <= plan_d;
      idx_q        <= idx_d;
      tmr_q        <= tmr_d;
      order_q      <= order_d;
      drinks_got_q <= drinks_got_d;
      half_left_q  <= half_left_d;
      one_left_q   <= one_left_d;
      coin_q       <= coin_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign coin       = coin_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign drinks_got = drinks_got_q;
  assign half_left  = half_left_q;
  assign one_left   = one_left_q;

endmodule

// File: tb/tb_coin_feeder.sv
// Directed bench for coin_feeder: one input vector per clock, outputs checked
// against hand-computed values at the falling edge.
module tb_coin_feeder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] order_cnt;
  logic [4:0] n_half;
  logic [4:0] n_one;
  logic       abort;
  logic       sell;
  logic [1:0] change;
  logic [1:0] coin;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] drinks_got;
  logic [4:0] half_left;
  logic [4:0] one_left;

  int n_vec  = 0;
  int n_miss = 0;

  coin_feeder #(.SELL_TIMEOUT(4), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .order_cnt  (order_cnt),
    .n_half     (n_half),
    .n_one      (n_one),
    .abort      (abort),
    .sell       (sell),
    .change     (change),
    .coin       (coin),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .drinks_got (drinks_got),
    .half_left  (half_left),
    .one_left   (one_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one input vector at the falling edge, then advance one full cycle.
  task automatic applyStimulus(input logic st, input logic [3:0] oc, input logic [4:0] nh,
                               input logic [4:0] no, input logic ab, input logic sl,
                               input logic [1:0] ch);
    start     = st;
    order_cnt = oc;
    n_half    = nh;
    n_one     = no;
    abort     = ab;
    sell      = sl;
    change    = ch;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] e_coin, input logic e_busy,
                             input logic e_done, input logic e_err, input logic [3:0] e_drinks,
                             input logic [4:0] e_half, input logic [4:0] e_one);
    logic [18:0] obs;
    logic [18:0] exp;
    obs = {coin, busy, done, err, drinks_got, half_left, one_left};
    exp = {e_coin, e_busy, e_done, e_err, e_drinks, e_half, e_one};
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("[TB] FAIL %s: got coin=%b busy=%b done=%b err=%b drinks=%0d half=%0d one=%0d, expected coin=%b busy=%b done=%b err=%b drinks=%0d half=%0d one=%0d",
             tag, coin, busy, done, err, drinks_got, half_left, one_left,
             e_coin, e_busy, e_done, e_err, e_drinks, e_half, e_one);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; order_cnt = 4'd0; n_half = 5'd0; n_one = 5'd0;
    abort = 1'b0; sell = 1'b0; change = 2'b00;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", 2'b00, 0, 0, 0, 4'd0, 5'd0, 5'd0);
    rst = 1'b0;

    // Two drinks paid {1, 0.5} each; start taken on first edge after reset release.
    applyStimulus(1, 4'd2, 5'd2, 5'd2, 0, 0, 2'b00); checkOutput("t1_plan0",   2'b00, 1, 0, 0, 4'd0, 5'd2, 5'd2);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t1_ins_one", 2'b10, 1, 0, 0, 4'd0, 5'd2, 5'd1);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t1_gap",     2'b00, 1, 0, 0, 4'd0, 5'd2, 5'd1);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t1_ins_half",2'b01, 1, 0, 0, 4'd0, 5'd1, 5'd1);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t1_wait",    2'b00, 1, 0, 0, 4'd0, 5'd1, 5'd1);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 1, 2'b00); checkOutput("t1_sold1",   2'b00, 1, 0, 0, 4'd1, 5'd1, 5'd1);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t1_ins2_one",2'b10, 1, 0, 0, 4'd1, 5'd1, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t1_gap2",    2'b00, 1, 0, 0, 4'd1, 5'd1, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t1_ins2_hf", 2'b01, 1, 0, 0, 4'd1, 5'd0, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t1_wait2",   2'b00, 1, 0, 0, 4'd1, 5'd0, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 1, 2'b00); checkOutput("t1_sold2",   2'b00, 1, 0, 0, 4'd2, 5'd0, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t1_done",    2'b00, 1, 1, 0, 4'd2, 5'd0, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t1_idle",    2'b00, 0, 0, 0, 4'd2, 5'd0, 5'd0);

    // Overpay with two 1-yuan coins, change returned; a start while busy is ignored.
    applyStimulus(1, 4'd1, 5'd0, 5'd2, 0, 0, 2'b00); checkOutput("t2_plan",    2'b00, 1, 0, 0, 4'd0, 5'd0, 5'd2);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t2_ins1",    2'b10, 1, 0, 0, 4'd0, 5'd0, 5'd1);
    applyStimulus(1, 4'd9, 5'd7, 5'd7, 0, 0, 2'b00); checkOutput("t2_gap_busy_start", 2'b00, 1, 0, 0, 4'd0, 5'd0, 5'd1);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t2_ins2",    2'b10, 1, 0, 0, 4'd0, 5'd0, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t2_wait",    2'b00, 1, 0, 0, 4'd0, 5'd0, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 1, 2'b01); checkOutput("t2_change",  2'b00, 1, 0, 0, 4'd1, 5'd1, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t2_done",    2'b00, 1, 1, 0, 4'd1, 5'd1, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t2_idle",    2'b00, 0, 0, 0, 4'd1, 5'd1, 5'd0);

    // Three halves for drink 1, then the wallet is empty.
    applyStimulus(1, 4'd2, 5'd3, 5'd0, 0, 0, 2'b00); checkOutput("t3_plan",    2'b00, 1, 0, 0, 4'd0, 5'd3, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t3_ins1",    2'b01, 1, 0, 0, 4'd0, 5'd2, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t3_gap1",    2'b00, 1, 0, 0, 4'd0, 5'd2, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t3_ins2",    2'b01, 1, 0, 0, 4'd0, 5'd1, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t3_gap2",    2'b00, 1, 0, 0, 4'd0, 5'd1, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t3_ins3",    2'b01, 1, 0, 0, 4'd0, 5'd0, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t3_wait",    2'b00, 1, 0, 0, 4'd0, 5'd0, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 1, 2'b00); checkOutput("t3_sold",    2'b00, 1, 0, 0, 4'd1, 5'd0, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t3_nofunds", 2'b00, 1, 0, 1, 4'd1, 5'd0, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t3_idle",    2'b00, 0, 0, 0, 4'd1, 5'd0, 5'd0);

    // Machine never answers: err four cycles after WAIT_SELL entry.
    applyStimulus(1, 4'd1, 5'd1, 5'd1, 0, 0, 2'b00); checkOutput("t4_plan",    2'b00, 1, 0, 0, 4'd0, 5'd1, 5'd1);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t4_ins1",    2'b10, 1, 0, 0, 4'd0, 5'd1, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t4_gap",     2'b00, 1, 0, 0, 4'd0, 5'd1, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t4_ins2",    2'b01, 1, 0, 0, 4'd0, 5'd0, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t4_wait0",   2'b00, 1, 0, 0, 4'd0, 5'd0, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t4_wait1",   2'b00, 1, 0, 0, 4'd0, 5'd0, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t4_wait2",   2'b00, 1, 0, 0, 4'd0, 5'd0, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t4_wait3",   2'b00, 1, 0, 0, 4'd0, 5'd0, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t4_timeout", 2'b00, 1, 0, 1, 4'd0, 5'd0, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t4_idle",    2'b00, 0, 0, 0, 4'd0, 5'd0, 5'd0);

    // Abort raised in GAP of drink 1: that drink completes, then done.
    applyStimulus(1, 4'd2, 5'd2, 5'd2, 0, 0, 2'b00); checkOutput("t5_plan",    2'b00, 1, 0, 0, 4'd0, 5'd2, 5'd2);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t5_ins1",    2'b10, 1, 0, 0, 4'd0, 5'd2, 5'd1);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t5_gap",     2'b00, 1, 0, 0, 4'd0, 5'd2, 5'd1);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 1, 0, 2'b00); checkOutput("t5_ins2",    2'b01, 1, 0, 0, 4'd0, 5'd1, 5'd1);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 1, 0, 2'b00); checkOutput("t5_wait",    2'b00, 1, 0, 0, 4'd0, 5'd1, 5'd1);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 1, 1, 2'b00); checkOutput("t5_sold",    2'b00, 1, 0, 0, 4'd1, 5'd1, 5'd1);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 1, 0, 2'b00); checkOutput("t5_abort",   2'b00, 1, 1, 0, 4'd1, 5'd1, 5'd1);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t5_idle",    2'b00, 0, 0, 0, 4'd1, 5'd1, 5'd1);

    // Stray sell while in PLAN is a protocol error.
    applyStimulus(1, 4'd1, 5'd1, 5'd1, 0, 0, 2'b00); checkOutput("t6_plan",    2'b00, 1, 0, 0, 4'd0, 5'd1, 5'd1);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 1, 2'b00); checkOutput("t6_stray",   2'b00, 1, 0, 1, 4'd0, 5'd1, 5'd1);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t6_idle",    2'b00, 0, 0, 0, 4'd0, 5'd1, 5'd1);

    // Zero-drink order finishes with done and drives no coin.
    applyStimulus(1, 4'd0, 5'd4, 5'd4, 0, 0, 2'b00); checkOutput("t7_plan",    2'b00, 1, 0, 0, 4'd0, 5'd4, 5'd4);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t7_done",    2'b00, 1, 1, 0, 4'd0, 5'd4, 5'd4);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t7_idle",    2'b00, 0, 0, 0, 4'd0, 5'd4, 5'd4);

    // Reset during INSERT clears everything at once and leaves no pulse behind.
    applyStimulus(1, 4'd1, 5'd1, 5'd1, 0, 0, 2'b00); checkOutput("t8_plan",    2'b00, 1, 0, 0, 4'd0, 5'd1, 5'd1);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t8_ins",     2'b10, 1, 0, 0, 4'd0, 5'd1, 5'd0);
    rst = 1'b1;
    #1;
    checkOutput("t8_async_rst", 2'b00, 0, 0, 0, 4'd0, 5'd0, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t8_post1",   2'b00, 0, 0, 0, 4'd0, 5'd0, 5'd0);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t8_post2",   2'b00, 0, 0, 0, 4'd0, 5'd0, 5'd0);

    // Fresh start right after reset release, aborted straight away.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 4'd3, 5'd5, 5'd6, 0, 0, 2'b00); checkOutput("t9_first_edge", 2'b00, 1, 0, 0, 4'd0, 5'd5, 5'd6);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 1, 0, 2'b00); checkOutput("t9_abort",   2'b00, 1, 1, 0, 4'd0, 5'd5, 5'd6);
    applyStimulus(0, 4'd0, 5'd0, 5'd0, 0, 0, 2'b00); checkOutput("t9_idle",    2'b00, 0, 0, 0, 4'd0, 5'd5, 5'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
